// File: rtl/down_timer.sv
// down_timer: prescaled countdown timer with one-shot / auto-reload modes.
// Loads via valid/ready while not running; start/stop strobes control run.
module down_timer #(
    parameter int COUNT_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [COUNT_WIDTH-1:0]    load_value,
    input  logic [PRESCALE_WIDTH-1:0] load_prescale,
    input  logic                      load_auto,
    input  logic                      start,
    input  logic                      stop,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      busy,
    output logic                      tc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]    C_ONE = 1;
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE = 1;

    state_t                      state_q;
    logic [COUNT_WIDTH-1:0]      count_q;
    logic [COUNT_WIDTH-1:0]      reload_q;
    logic [PRESCALE_WIDTH-1:0]   presc_q;
    logic [PRESCALE_WIDTH-1:0]   pcnt_q;
    logic                        auto_q;
    logic                        tc_q;

    logic                        load_fire;
    logic [COUNT_WIDTH-1:0]      start_cnt;
    logic                        go;
    logic                        tick;

    // Start is judged against the count as it will be after any same-cycle load.
    always_comb begin
        load_fire = load_valid && (state_q != RUN);
        start_cnt = load_fire ? load_value : count_q;
        go        = start && !stop && (start_cnt != '0);
        tick      = (pcnt_q == '0);
    end

    // Run-control FSM, prescaler and counter; tc is a one-cycle registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            auto_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            unique case (state_q)
                IDLE, PAUSED: begin
                    if (load_fire) begin
                        reload_q <= load_value;
                        count_q  <= load_value;
                        presc_q  <= load_prescale;
                        pcnt_q   <= load_prescale;
                        auto_q   <= load_auto;
                    end
                    if (go) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= PAUSED;
                    end else if (!tick) begin
                        pcnt_q <= pcnt_q - P_ONE;
                    end else begin
                        pcnt_q <= presc_q;
                        if (count_q > C_ONE) begin
                            count_q <= count_q - C_ONE;
                        end else begin
                            tc_q <= 1'b1;
                            if (auto_q) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= '0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        count      = count_q;
        busy       = (state_q == RUN);
        load_ready = (state_q != RUN);
        tc         = tc_q;
    end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus for down_timer, checked every cycle
// against an elapsed-time model plus hand-computed literal expectations.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = '0;
    logic [3:0] load_prescale = '0;
    logic       load_auto = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       tc;

    int nvec = 0;
    int nerr = 0;

    down_timer #(
        .COUNT_WIDTH(8),
        .PRESCALE_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .load_prescale(load_prescale),
        .load_auto(load_auto),
        .start(start),
        .stop(stop),
        .count(count),
        .busy(busy),
        .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 paused; count derived from elapsed clocks.
    int m_mode = 0;
    int m_v = 0;
    int m_p = 0;
    int m_auto = 0;
    int m_el = 0;
    int m_cnt = 0;
    int m_tc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_v = 0; m_p = 0; m_auto = 0;
            m_el = 0; m_cnt = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (m_mode != 1) begin
                if (load_valid) begin
                    m_v = load_value;
                    m_p = load_prescale;
                    m_auto = load_auto;
                    m_cnt = m_v;
                    m_el = 0;
                end
                if (start && !stop && m_cnt != 0) m_mode = 1;
            end else if (stop) begin
                m_mode = 2;
            end else begin
                m_el++;
                if (m_el == m_v * (m_p + 1)) begin
                    m_tc = 1;
                    if (m_auto != 0) begin
                        m_el = 0;
                        m_cnt = m_v;
                    end else begin
                        m_mode = 0;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = m_v - m_el / (m_p + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model count", count, m_cnt);
        chk("model busy", busy, (m_mode == 1));
        chk("model load_ready", load_ready, (m_mode != 1));
        chk("model tc", tc, m_tc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v, input int p, input int a);
        load_valid = 1'b1;
        load_value = v[7:0];
        load_prescale = p[3:0];
        load_auto = a[0];
        step(1);
        load_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset count", count, 0);
        chk("reset busy", busy, 0);
        chk("reset tc", tc, 0);
        chk("reset load_ready", load_ready, 1);
        rst = 1'b0;
        step(1);

        // one-shot V=5 P=0
        do_load(5, 0, 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("os start busy", busy, 1);
        chk("os start count", count, 5);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("os count", count, 5 - k);
        end
        chk("os tc", tc, 1);
        chk("os busy end", busy, 0);
        step(1);
        chk("os tc clear", tc, 0);

        // auto-reload V=3 P=2: period 9
        do_load(3, 2, 1);
        start = 1'b1; step(1); start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step(1);
            chk("ar count", count, 3 - (k % 9) / 3);
            chk("ar tc", tc, (k % 9) == 0);
        end
        stop = 1'b1; step(1); stop = 1'b0;
        chk("ar paused busy", busy, 0);

        // pause/resume V=4 P=1 one-shot, loaded while PAUSED
        do_load(4, 1, 0);
        chk("pr load count", count, 4);
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("pr paused count", count, 3);
        chk("pr paused busy", busy, 0);
        step(8);
        chk("pr frozen count", count, 3);
        chk("pr frozen ready", load_ready, 1);
        start = 1'b1; step(1); start = 1'b0;
        chk("pr resume busy", busy, 1);
        step(5);
        chk("pr N+17 count", count, 1);
        chk("pr N+17 tc", tc, 0);
        step(1);
        chk("pr N+18 tc", tc, 1);
        chk("pr N+18 count", count, 0);
        chk("pr N+18 busy", busy, 0);

        // load held during RUN
        do_load(6, 0, 0);
        start = 1'b1; step(1); start = 1'b0;
        load_valid = 1'b1; load_value = 8'd9;
        load_prescale = 4'd3; load_auto = 1'b0;
        step(5);
        chk("hold count", count, 1);
        chk("hold ready", load_ready, 0);
        step(1);
        chk("hold end count", count, 0);
        chk("hold end tc", tc, 1);
        chk("hold end ready", load_ready, 1);
        step(1);
        chk("hold accepted count", count, 9);
        chk("hold accepted busy", busy, 0);
        load_valid = 1'b0;

        // zero rule
        do_load(0, 0, 0);
        chk("zero count", count, 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("zero start busy", busy, 0);

        // same-cycle events
        load_valid = 1'b1; load_value = 8'd7;
        load_prescale = 4'd0; load_auto = 1'b0;
        start = 1'b1; step(1);
        load_valid = 1'b0; start = 1'b0;
        chk("ld+start busy", busy, 1);
        chk("ld+start count", count, 7);
        step(1);
        chk("ld+start dec", count, 6);
        start = 1'b1; stop = 1'b1; step(1);
        start = 1'b0; stop = 1'b0;
        chk("start+stop busy", busy, 0);
        chk("start+stop count", count, 6);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("stop paused", busy, 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("resume busy", busy, 1);
        chk("resume count", count, 6);
        step(1);
        chk("resume dec", count, 5);
        stop = 1'b1; step(1); stop = 1'b0;
        load_valid = 1'b1; load_value = 8'd0; start = 1'b1;
        step(1);
        load_valid = 1'b0; start = 1'b0;
        chk("ld0+start busy", busy, 0);
        chk("ld0+start count", count, 0);

        // asynchronous reset mid-count
        do_load(200, 15, 0);
        start = 1'b1; step(1); start = 1'b0;
        step(20);
        chk("long count", count, 199);
        #2;
        rst = 1'b1;
        #1;
        chk("arst count", count, 0);
        chk("arst busy", busy, 0);
        chk("arst tc", tc, 0);
        chk("arst ready", load_ready, 1);
        #3;
        rst = 1'b0;
        step(1);
        load_valid = 1'b1; load_value = 8'd0; start = 1'b1;
        step(1);
        load_valid = 1'b0; start = 1'b0;
        chk("idle ld0+start busy", busy, 0);

        // V=1 auto P=0: tc continuously high
        do_load(1, 0, 1);
        start = 1'b1; step(1); start = 1'b0;
        chk("v1 busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("v1 tc", tc, 1);
            chk("v1 count", count, 1);
        end
        stop = 1'b1; step(1); stop = 1'b0;
        chk("v1 stop tc", tc, 0);
        chk("v1 stop busy", busy, 0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable countdown timer: counts down from a loaded value at a prescaled rate and pulses a terminal-count flag on reaching zero, in one-shot or auto-reload mode. It sits beside the up-counter in the common-blocks library as the decrementing, event-generating counterpart. Typical uses are timeouts, periodic ticks and baud/strobe generation. Configuration is loaded through a valid/ready handshake, and start/stop strobes provide run control.

## Interface
- COUNT_WIDTH, 8, width of the count and reload registers
- PRESCALE_WIDTH, 4, width of the prescale divider; count decrements once every P+1 clocks
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- load_valid  input  1  configuration load request
- load_ready  output  1  high when a load can be accepted (state IDLE or PAUSED)
- load_value  input  COUNT_WIDTH  initial count and reload value V
- load_prescale  input  PRESCALE_WIDTH  prescale value P
- load_auto  input  1  1 = auto-reload mode, 0 = one-shot mode
- start  input  1  single-cycle strobe to run or resume
- stop  input  1  single-cycle strobe to pause
- count  output  COUNT_WIDTH  current count
- busy  output  1  high while state is RUN
- tc  output  1  terminal-count pulse, one clock wide

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSED
- Internal registers:
  - reload_r (COUNT_WIDTH)
  - presc_r (PRESCALE_WIDTH)
  - pcnt (PRESCALE_WIDTH)
  - auto_r
- Load is accepted when load_valid && load_ready:
  - reload_r <= load_value; count <= load_value
  - presc_r <= load_prescale; pcnt <= load_prescale
  - auto_r <= load_auto
  - State does not change.
- Load with load_ready low: ignored. The requester holds load_valid until accepted.
- IDLE -> RUN on start, if the post-load count is nonzero. Start with count == 0 is ignored and the state stays IDLE.
- PAUSED -> RUN on start, under the same nonzero rule. pcnt and count resume from their held values.
- RUN -> PAUSED on stop. count and pcnt freeze.
- stop in IDLE or PAUSED: ignored.
- start and stop in the same cycle: stop wins.
  - RUN -> PAUSED.
  - IDLE/PAUSED: no state change.
- Start while RUN: ignored.
- Prescaler in RUN:
  - pcnt != 0: pcnt <= pcnt - 1.
  - pcnt == 0: a tick occurs and pcnt <= presc_r.
- Tick with count > 1: count <= count - 1.
- Tick with count == 1, one-shot: count <= 0, tc <= 1, RUN -> IDLE.
- Tick with count == 1, auto-reload: count <= reload_r, tc <= 1, stay in RUN.
- Load and start in the same cycle from IDLE or PAUSED: the load applies first. Start is evaluated against load_value, so load_value == 0 leaves the block not running.
- Loads never occur in RUN, since load_ready is low there.
- Arithmetic:
  - All counting is unsigned.
  - count never decrements below 0 and never wraps.
  - pcnt reloads rather than wrapping.
- Reset mid-operation: all state returns to reset values immediately. Any tc in progress is cleared.

## Timing
- Reset values:
  - count = 0, busy = 0, tc = 0, load_ready = 1
  - state IDLE
  - reload_r, presc_r, pcnt, auto_r = 0
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- load_ready = (state != RUN), state-decoded. It deasserts the cycle after the start edge.
- Start sampled at edge N from IDLE with a fresh load:
  - busy = 1 after edge N.
  - First decrement at edge N+P+1.
  - count reaches 0 (or reloads) at edge N+V*(P+1).
- tc is high for exactly the one cycle following the terminal tick edge.
- In one-shot mode, busy falls on the same edge that tc rises.
- In auto-reload mode, tc repeats every V*(P+1) clocks.
- P = 0: decrement every clock. V = 1 with auto-reload and P = 0: tc is high continuously while running, because it is re-asserted every cycle.
- Pause/resume:
  - The pause adds exactly the paused cycle count to the terminal time.
  - No ticks are lost or duplicated.

## Test plan
- Reset, then load V=5 P=0 one-shot, start at edge N:
  - count reads 4,3,2,1,0 after edges N+1..N+5.
  - tc high for one cycle after N+5.
  - busy low from N+5.
- Load V=3 P=2 auto-reload, start:
  - tc pulses every 9 clocks.
  - count sequence is 3 (3 clk), 2 (3 clk), 1 (3 clk), 3, and so on.
- V=4 P=1 one-shot:
  - Stop 3 cycles after start, hold PAUSED for 10 cycles, then start.
  - tc is exactly 10 cycles later than the unpaused case (edge N+8 becomes N+18).
  - count is frozen while PAUSED.
- Loads and the zero rule:
  - load_valid held during RUN: not accepted until after the one-shot completes. Then accepted: load_ready=1, count=load_value.
  - Start with count=0: busy stays 0.
- Same-cycle events:
  - start+stop together in RUN: pauses.
  - load(V=7)+start together in IDLE: runs from 7.
  - load(V=0)+start: stays IDLE.
- Assert rst mid-count with V=200 P=15:
  - count=0, busy=0, tc=0 and load_ready=1 immediately, without waiting for a clock.
  - After a reload and start, normal operation resumes.
